// File: rtl/acc_bank.sv
// acc_bank: bank of NUM_ACC accumulators of WIDTH bits with a DEPTH-entry save stack.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            synchronous clear (highest priority)
//   load_acc       write alu_out into acc[acc_sel]
//   push           push acc[acc_sel] onto the save stack
//   pop            pop stack top into acc[acc_sel]
//   acc_sel        accumulator index for read/load/push/pop
//   alu_out        ALU result
//   acc_out        combinational read of acc[acc_sel] (0 when out of range)
//   zero, neg      flags derived from acc_out
//   stk_level      number of valid stack entries
//   stk_empty      stk_level == 0
//   stk_full       stk_level == DEPTH
//   err            sticky error: illegal command mix, bad index, overflow, underflow
module acc_bank #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NUM_ACC = 4,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned SW     = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1,
    localparam int unsigned LW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load_acc,
    input  logic             push,
    input  logic             pop,
    input  logic [SW-1:0]    acc_sel,
    input  logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] acc_out,
    output logic             zero,
    output logic             neg,
    output logic [LW-1:0]    stk_level,
    output logic             stk_empty,
    output logic             stk_full,
    output logic             err
);

    logic [WIDTH-1:0] acc_q [NUM_ACC];
    logic [WIDTH-1:0] acc_d [NUM_ACC];
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] stk_d [DEPTH];
    logic [LW-1:0]    sp_q, sp_d;
    logic             err_q, err_d;

    logic [31:0]      sel_ext, sp_ext;
    logic             sel_ok, is_full, is_empty, any_cmd, multi_cmd;
    logic [WIDTH-1:0] acc_rd, stk_top;

    // Widen indices to 32 bits so range checks work for any parameter set.
    assign sel_ext   = 32'(acc_sel);
    assign sp_ext    = 32'(sp_q);
    assign sel_ok    = sel_ext < NUM_ACC;
    assign is_full   = sp_ext == DEPTH;
    assign is_empty  = sp_q == '0;
    assign any_cmd   = load_acc | push | pop;
    assign multi_cmd = (load_acc & push) | (load_acc & pop) | (push & pop);

    // Read muxes; an out-of-range select reads as zero.
    always_comb begin
        acc_rd = '0;
        for (int unsigned i = 0; i < NUM_ACC; i++) begin
            if (sel_ext == i) acc_rd = acc_q[i];
        end
    end

    always_comb begin
        stk_top = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            if (sp_ext == j + 1) stk_top = stk_q[j];
        end
    end

    always_comb begin
        acc_d = acc_q;
        stk_d = stk_q;
        sp_d  = sp_q;
        err_d = err_q;
        if (clr) begin
            for (int unsigned i = 0; i < NUM_ACC; i++) acc_d[i] = '0;
            for (int unsigned j = 0; j < DEPTH; j++) stk_d[j] = '0;
            sp_d  = '0;
            err_d = 1'b0;
        end else if (multi_cmd) begin
            err_d = 1'b1;
        end else if (any_cmd && !sel_ok) begin
            err_d = 1'b1;
        end else if (load_acc) begin
            for (int unsigned i = 0; i < NUM_ACC; i++) begin
                if (sel_ext == i) acc_d[i] = alu_out;
            end
        end else if (push) begin
            if (is_full) begin
                err_d = 1'b1;
            end else begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (sp_ext == j) stk_d[j] = acc_rd;
                end
                sp_d = sp_q + LW'(1);
            end
        end else if (pop) begin
            if (is_empty) begin
                err_d = 1'b1;
            end else begin
                // Popped entry is left stale in stk_q.
                for (int unsigned i = 0; i < NUM_ACC; i++) begin
                    if (sel_ext == i) acc_d[i] = stk_top;
                end
                sp_d = sp_q - LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
            for (int unsigned j = 0; j < DEPTH; j++) stk_q[j] <= '0;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            stk_q <= stk_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    assign acc_out   = acc_rd;
    assign zero      = (acc_rd == '0);
    assign neg       = acc_rd[WIDTH-1];
    assign stk_level = sp_q;
    assign stk_empty = is_empty;
    assign stk_full  = is_full;
    assign err       = err_q;

endmodule

// File: doc/acc_bank.md
# acc_bank

Parametrised accumulator bank for the CPU datapath, the next generation of the single 8-bit accumulator register. Holds NUM_ACC accumulators of WIDTH bits and loads the selected one from the ALU result. A DEPTH-entry save stack lets the controller push and pop the selected accumulator for call and interrupt context. Combinational zero and negative flags are produced for the branch logic.

## Interface
- WIDTH, 8, data width of each accumulator and of the stack entries.
- NUM_ACC, 4, number of accumulators; legal range 1..16.
- DEPTH, 4, save-stack depth; legal range 1..16.
- SW = max(1, clog2(NUM_ACC)), LW = clog2(DEPTH+1); derived widths, not overridable.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear; highest priority.
- load_acc  in  1  write alu_out into accumulator acc_sel.
- push  in  1  copy accumulator acc_sel onto the save stack.
- pop  in  1  restore the stack top into accumulator acc_sel.
- acc_sel  in  SW  accumulator index for the read, load, push and pop operations.
- alu_out  in  WIDTH  ALU result.
- acc_out  out  WIDTH  contents of accumulator acc_sel (combinational read).
- zero  out  1  acc_out == 0.
- neg  out  1  acc_out[WIDTH-1].
- stk_level  out  LW  number of valid stack entries.
- stk_empty  out  1  stk_level == 0.
- stk_full  out  1  stk_level == DEPTH.
- err  out  1  sticky error flag.

## Operation
- State consists of acc[0..NUM_ACC-1], stack[0..DEPTH-1], stack pointer sp (0..DEPTH) and err.
- Reset (rst_n low, asynchronous): all accumulators, all stack entries, sp and err are cleared to 0.
  - Resulting outputs: acc_out=0, zero=1, neg=0, stk_level=0, stk_empty=1, stk_full=0, err=0.
  - Reset asserted mid-operation discards any pending command. Nothing is partially written.
- Each cycle is evaluated in strict priority order:
  1. clr=1: same effect as reset, applied at the clock edge. All other inputs are ignored.
  2. More than one of load_acc, push, pop asserted: illegal. State is unchanged and err is set.
  3. acc_sel >= NUM_ACC while any command is asserted: no state change and err is set.
  4. load_acc: acc[acc_sel] <= alu_out.
  5. push: if sp==DEPTH, no change and err is set. Otherwise stack[sp] <= acc[acc_sel] and sp <= sp+1.
  6. pop: if sp==0, no change and err is set. Otherwise acc[acc_sel] <= stack[sp-1] and sp <= sp-1. The popped entry is left stale (not cleared).
  7. No command: hold all state.
- err is sticky. Only clr or rst_n clears it.
- Reading with acc_sel >= NUM_ACC (no command asserted) returns acc_out=0 and does not set err.
- Stack pointer arithmetic never wraps. Overflow and underflow are blocked, not wrapped.
- The push/pop LIFO order holds across accumulators: a value pushed from acc[i] may be popped into acc[j].

## Timing
- Writes take effect on the rising edge and are visible on acc_out, zero and neg in the next cycle.
- acc_out, zero and neg follow acc_sel combinationally within the same cycle, with no clock latency.
- stk_level, stk_empty and stk_full are decoded from registered sp, so they update one edge after the push or pop.
- err rises on the edge that samples the offending command.
- Back-to-back push/pop on consecutive cycles is supported at full rate. A pop in cycle n+1 returns the value pushed in cycle n.
- No input handshake: the controller must not issue a push when stk_full=1 or a pop when stk_empty=1. The block only flags these cases.

## Test plan
- Reset and load (WIDTH=8): release reset, then apply load_acc with acc_sel=2, alu_out=8'h80. One cycle later with acc_sel=2: acc_out=8'h80, neg=1, zero=0. With acc_sel=0: acc_out=0, zero=1.
- Stack round trip: acc0=8'h11, acc1=8'h22. Push acc0, push acc1, giving stk_level=2. Pop into acc3, giving acc3=8'h22. Pop into acc2, giving acc2=8'h11, stk_empty=1, err=0.
- Overflow and underflow (DEPTH=4): five consecutive pushes give stk_level=4, stk_full=1 and err=1 after the fifth, with stack contents unchanged. After clr, a pop gives err=1 and stk_level stays 0.
- Illegal combination: load_acc=1 and pop=1 in the same cycle with sp=1. Required: acc unchanged, sp=1, err=1. Then clr gives err=0 and all accumulators 0.
- Out-of-range index (NUM_ACC=3): a load with acc_sel=3 gives err=1, acc0..2 unchanged, and acc_out=0 while acc_sel=3.
- Asynchronous reset mid-burst: assert rst_n low between clock edges during a push sequence. Outputs immediately return to reset values, and the next push stores into stack[0].
